// File: rtl/vram_port_arbiter.sv
// ---------------------------------------------------------------------------
// vram_port_arbiter
//
// Shares one single-port synchronous VRAM (1-cycle read latency) between a
// display pixel-fetch engine and a host (AXI-side) request/response port.
// Pixel fetch always wins the port; the host is served by a small FSM
// (IDLE -> RD_WAIT -> RSP for reads, IDLE -> RSP for writes and errors).
//
// Ports
//   pixel_clk        : clock, all state updates on the rising edge
//   arstn            : synchronous active-low reset
//   pix_req/pix_addr : one-cycle pixel read request and word address
//   pix_rvalid/rdata : pixel read data, one cycle after pix_req
//   host_valid/ready : host request handshake (ready is combinational)
//   host_we/addr/wdata/wstrb : host write flag, word address, data, strobes
//   host_rsp_valid/ready     : host response handshake
//   host_rsp_data/err        : read data (0 for writes), out-of-range flag
//   mem_en/we/addr/wdata/rdata : VRAM port (byte write enables in mem_we)
//   host_stall_cnt   : saturating count of cycles the host was held off
// ---------------------------------------------------------------------------
module vram_port_arbiter #(
  parameter int DEPTH  = 600,
  parameter int ADDR_W = 10
) (
  input  logic              pixel_clk,
  input  logic              arstn,
  // pixel fetch port
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              pix_rvalid,
  output logic [31:0]       pix_rdata,
  // host request port
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  input  logic [3:0]        host_wstrb,
  // host response port
  output logic              host_rsp_valid,
  input  logic              host_rsp_ready,
  output logic [31:0]       host_rsp_data,
  output logic              host_rsp_err,
  // VRAM port
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  // statistics
  output logic [15:0]       host_stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RSP     = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic        pix_rvalid_q, pix_rvalid_d;
  logic [31:0] pix_hold_q,   pix_hold_d;
  logic [31:0] rsp_data_q,   rsp_data_d;
  logic        rsp_err_q,    rsp_err_d;
  logic [15:0] stall_q,      stall_d;

  logic        host_ready_s;
  logic        in_range_s;

  // Saturating increment: the stall counter must never wrap back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return 16'hFFFF;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Address range check done at 32 bits so DEPTH == 2**ADDR_W also works.
  always_comb begin
    in_range_s = (32'(host_addr) < 32'(DEPTH));
  end

  // ---------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (host_ready_s) begin
          // Only an in-range read needs the extra cycle for RAM latency.
          if (in_range_s && !host_we) begin
            state_d = ST_RD_WAIT;
          end else begin
            state_d = ST_RSP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (host_rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM process 3: outputs (handshakes and VRAM port mux)
  // ---------------------------------------------------------------------
  always_comb begin
    host_ready_s   = 1'b0;
    host_rsp_valid = 1'b0;
    mem_en         = 1'b0;
    mem_we         = 4'h0;
    mem_addr       = '0;
    mem_wdata      = 32'h0000_0000;

    // Host is only accepted when the port is free and the FSM is idle.
    if (arstn && (state_q == ST_IDLE) && host_valid && !pix_req) begin
      host_ready_s = 1'b1;
    end else begin
      host_ready_s = 1'b0;
    end

    if (state_q == ST_RSP) begin
      host_rsp_valid = 1'b1;
    end else begin
      host_rsp_valid = 1'b0;
    end

    // Port mux: reset silences everything, pixel fetch beats the host,
    // out-of-range host requests never touch the RAM.
    if (!arstn) begin
      mem_en = 1'b0;
    end else if (pix_req) begin
      mem_en   = 1'b1;
      mem_we   = 4'h0;
      mem_addr = pix_addr;
    end else if (host_ready_s && in_range_s) begin
      mem_en   = 1'b1;
      mem_addr = host_addr;
      if (host_we) begin
        mem_we    = host_wstrb;
        mem_wdata = host_wdata;
      end else begin
        mem_we    = 4'h0;
      end
    end else begin
      mem_en = 1'b0;
    end
  end

  assign host_ready = host_ready_s;

  // Datapath next-state: response register, pixel data hold, stall counter.
  always_comb begin
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    pix_rvalid_d = pix_req;
    pix_hold_d   = pix_hold_q;
    stall_d      = stall_q;

    case (state_q)
      ST_IDLE: begin
        if (host_ready_s) begin
          // Writes and errors answer with zero data; a good read fills
          // rsp_data in RD_WAIT once the RAM output is valid.
          if (!in_range_s) begin
            rsp_data_d = 32'h0000_0000;
            rsp_err_d  = 1'b1;
          end else if (host_we) begin
            rsp_data_d = 32'h0000_0000;
            rsp_err_d  = 1'b0;
          end else begin
            rsp_err_d  = 1'b0;
          end
        end else begin
          rsp_err_d = rsp_err_q;
        end
      end
      ST_RD_WAIT: begin
        // RAM output belongs to the host read issued last cycle, even if a
        // pixel request owns the port right now.
        rsp_data_d = mem_rdata;
        rsp_err_d  = 1'b0;
      end
      ST_RSP: begin
        rsp_data_d = rsp_data_q;
      end
      default: begin
        rsp_data_d = rsp_data_q;
      end
    endcase

    // Keep the last pixel word visible after pix_rvalid drops.
    if (pix_rvalid_q) begin
      pix_hold_d = mem_rdata;
    end else begin
      pix_hold_d = pix_hold_q;
    end

    if (host_valid && !host_ready_s) begin
      stall_d = sat_inc16(stall_q);
    end else begin
      stall_d = stall_q;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      rsp_data_q   <= 32'h0000_0000;
      rsp_err_q    <= 1'b0;
      pix_rvalid_q <= 1'b0;
      pix_hold_q   <= 32'h0000_0000;
      stall_q      <= 16'h0000;
    end else begin
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      pix_rvalid_q <= pix_rvalid_d;
      pix_hold_q   <= pix_hold_d;
      stall_q      <= stall_d;
    end
  end

  // Output drive; pixel data passes the RAM output straight through in
  // the valid cycle so it lines up with pix_rvalid.
  always_comb begin
    pix_rvalid     = pix_rvalid_q;
    host_rsp_data  = rsp_data_q;
    host_rsp_err   = rsp_err_q;
    host_stall_cnt = stall_q;
    if (pix_rvalid_q) begin
      pix_rdata = mem_rdata;
    end else begin
      pix_rdata = pix_hold_q;
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
module tb_vram_port_arbiter;

  localparam int DEPTH  = 600;
  localparam int ADDR_W = 10;

  logic              pixel_clk = 1'b0;
  logic              arstn;
  logic              pix_req;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_rvalid;
  logic [31:0]       pix_rdata;
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic [3:0]        host_wstrb;
  logic              host_rsp_valid;
  logic              host_rsp_ready;
  logic [31:0]       host_rsp_data;
  logic              host_rsp_err;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [15:0]       host_stall_cnt;

  vram_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .pixel_clk      (pixel_clk),
    .arstn          (arstn),
    .pix_req        (pix_req),
    .pix_addr       (pix_addr),
    .pix_rvalid     (pix_rvalid),
    .pix_rdata      (pix_rdata),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_wstrb     (host_wstrb),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_ready (host_rsp_ready),
    .host_rsp_data  (host_rsp_data),
    .host_rsp_err   (host_rsp_err),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .host_stall_cnt (host_stall_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Physical RAM seen by the DUT, and the bench's reference contents.
  logic [31:0] ram     [0:1023];
  logic [31:0] ref_mem [0:1023];

  // Model state: transaction-level view of the host and pixel ports.
  bit          m_pending;
  int          m_wait;
  logic [31:0] m_rsp_data;
  bit          m_rsp_err;
  bit          m_pix_v;
  logic [31:0] m_pix_d;
  logic [31:0] m_pix_hold;
  int          m_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous single-port RAM, one-cycle read latency, byte writes.
  always @(posedge pixel_clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Model update on each rising edge from the inputs that were presented.
  always @(posedge pixel_clk) begin
    bit rdy;
    bit inr;
    if (!arstn) begin
      m_pending  = 1'b0;
      m_wait     = 0;
      m_pix_v    = 1'b0;
      m_pix_hold = 32'h0;
      m_stall    = 0;
      m_rsp_data = 32'h0;
      m_rsp_err  = 1'b0;
    end else begin
      rdy = !m_pending && host_valid && !pix_req;
      inr = (int'(host_addr) < DEPTH);
      if (host_valid && !rdy && m_stall < 65535) m_stall++;
      if (m_pix_v) m_pix_hold = m_pix_d;
      m_pix_v = pix_req;
      if (pix_req) m_pix_d = ref_mem[pix_addr];
      if (m_pending) begin
        if (m_wait > 0) m_wait--;
        else if (host_rsp_ready) m_pending = 1'b0;
      end else if (rdy) begin
        m_pending = 1'b1;
        if (!inr) begin
          m_rsp_data = 32'h0; m_rsp_err = 1'b1; m_wait = 0;
        end else if (host_we) begin
          for (int b = 0; b < 4; b++)
            if (host_wstrb[b]) ref_mem[host_addr][8*b +: 8] = host_wdata[8*b +: 8];
          m_rsp_data = 32'h0; m_rsp_err = 1'b0; m_wait = 0;
        end else begin
          m_rsp_data = ref_mem[host_addr]; m_rsp_err = 1'b0; m_wait = 1;
        end
      end
    end
  end

  // Compare process: every falling edge once reset has been applied.
  always @(negedge pixel_clk) begin
    bit rdy;
    bit inr;
    if (chk_en) begin
      rdy = arstn && !m_pending && host_valid && !pix_req;
      inr = (int'(host_addr) < DEPTH);
      chk("host_ready", 32'(host_ready), 32'(rdy));
      if (!arstn) begin
        chk("mem_en_rst", 32'(mem_en), 32'd0);
        chk("mem_we_rst", 32'(mem_we), 32'd0);
        chk("mem_addr_rst", 32'(mem_addr), 32'd0);
        chk("mem_wdata_rst", mem_wdata, 32'd0);
      end else if (pix_req) begin
        chk("mem_en_pix", 32'(mem_en), 32'd1);
        chk("mem_we_pix", 32'(mem_we), 32'd0);
        chk("mem_addr_pix", 32'(mem_addr), 32'(pix_addr));
      end else if (rdy && inr) begin
        chk("mem_en_host", 32'(mem_en), 32'd1);
        chk("mem_we_host", 32'(mem_we), host_we ? 32'(host_wstrb) : 32'd0);
        chk("mem_addr_host", 32'(mem_addr), 32'(host_addr));
        if (host_we) chk("mem_wdata_host", mem_wdata, host_wdata);
      end else begin
        chk("mem_en_idle", 32'(mem_en), 32'd0);
        chk("mem_we_idle", 32'(mem_we), 32'd0);
      end
      chk("rsp_valid", 32'(host_rsp_valid), 32'(m_pending && m_wait == 0));
      if (m_pending && m_wait == 0) begin
        chk("rsp_data", host_rsp_data, m_rsp_data);
        chk("rsp_err", 32'(host_rsp_err), 32'(m_rsp_err));
      end
      chk("pix_rvalid", 32'(pix_rvalid), 32'(m_pix_v));
      chk("pix_rdata", pix_rdata, m_pix_v ? m_pix_d : m_pix_hold);
      chk("stall_cnt", 32'(host_stall_cnt), 32'(m_stall));
    end
  end

  task automatic nx();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge pixel_clk);
  endtask

  task automatic host_req(input bit we, input int addr, input logic [31:0] d, input logic [3:0] s);
    host_valid = 1'b1;
    host_we    = we;
    host_addr  = ADDR_W'(addr);
    host_wdata = d;
    host_wstrb = s;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    arstn = 1'b0; pix_req = 1'b1; pix_addr = 10'd3;
    host_req(1'b1, 5, 32'h1111_1111, 4'hF);
    host_rsp_ready = 1'b1;

    // Reset: port silenced, host held off, registers cleared.
    nx();
    chk_en = 1'b1;
    at_neg();
    chk("lit_rst_mem_en", 32'(mem_en), 32'd0);
    chk("lit_rst_ready", 32'(host_ready), 32'd0);
    chk("lit_rst_pix_rvalid", 32'(pix_rvalid), 32'd0);
    chk("lit_rst_pix_rdata", pix_rdata, 32'd0);
    chk("lit_rst_rsp_valid", 32'(host_rsp_valid), 32'd0);
    chk("lit_rst_stall", 32'(host_stall_cnt), 32'd0);
    nx();
    arstn = 1'b1; pix_req = 1'b0; host_valid = 1'b0;
    nx();

    // Host write addr 5, then read it back.
    host_req(1'b1, 5, 32'h1234_5678, 4'hF);
    at_neg();
    chk("lit_wr_mem_we", 32'(mem_we), 32'hF);
    chk("lit_wr_mem_addr", 32'(mem_addr), 32'd5);
    nx(); host_valid = 1'b0;
    at_neg();
    chk("lit_wr_rsp_valid", 32'(host_rsp_valid), 32'd1);
    chk("lit_wr_rsp_err", 32'(host_rsp_err), 32'd0);
    nx();
    host_req(1'b0, 5, 32'h0, 4'h0);
    nx(); host_valid = 1'b0;
    at_neg();
    chk("lit_rd_wait_valid", 32'(host_rsp_valid), 32'd0);
    nx();
    at_neg();
    chk("lit_rd_rsp_data", host_rsp_data, 32'h1234_5678);
    nx();

    // Pixel fetch for 10 cycles starves a waiting host read.
    for (int i = 0; i < 10; i++) begin
      pix_req = 1'b1; pix_addr = ADDR_W'(10 + i);
      host_req(1'b0, 20, 32'h0, 4'h0);
      nx();
    end
    pix_req = 1'b0;
    at_neg();
    chk("lit_stall10", 32'(host_stall_cnt), 32'd10);
    chk("lit_ready_after_pix", 32'(host_ready), 32'd1);
    chk("lit_pix_last", pix_rdata, 32'hA500_0013);
    nx(); host_valid = 1'b0;
    nx();
    at_neg();
    chk("lit_rd20", host_rsp_data, 32'hA500_0014);
    nx();

    // Host read addr 7 with a pixel read of addr 3 during RD_WAIT.
    host_req(1'b0, 7, 32'h0, 4'h0);
    nx(); host_valid = 1'b0; pix_req = 1'b1; pix_addr = 10'd3;
    nx(); pix_req = 1'b0;
    at_neg();
    chk("lit_mix_host", host_rsp_data, 32'hA500_0007);
    chk("lit_mix_pix", pix_rdata, 32'hA500_0003);
    nx();

    // Address boundary: 600 is out of range, 599 is the last word.
    host_req(1'b1, 600, 32'hDEAD_BEEF, 4'hF);
    at_neg();
    chk("lit_oob_mem_en", 32'(mem_en), 32'd0);
    nx(); host_valid = 1'b0;
    at_neg();
    chk("lit_oob_err", 32'(host_rsp_err), 32'd1);
    chk("lit_oob_data", host_rsp_data, 32'd0);
    nx();
    host_req(1'b1, 599, 32'hCAFE_F00D, 4'b0101);
    nx(); host_valid = 1'b0;
    at_neg();
    chk("lit_599_err", 32'(host_rsp_err), 32'd0);
    nx();
    host_req(1'b0, 599, 32'h0, 4'h0);
    nx(); host_valid = 1'b0;
    nx();
    at_neg();
    chk("lit_599_strb", host_rsp_data, 32'hA5FE_020D);
    nx();

    // Zero-strobe write: port enabled, nothing written.
    host_req(1'b1, 8, 32'hFFFF_FFFF, 4'h0);
    at_neg();
    chk("lit_strb0_en", 32'(mem_en), 32'd1);
    chk("lit_strb0_we", 32'(mem_we), 32'd0);
    nx(); host_valid = 1'b0;
    nx();
    host_req(1'b0, 8, 32'h0, 4'h0);
    nx(); host_valid = 1'b0;
    nx();
    at_neg();
    chk("lit_strb0_data", host_rsp_data, 32'hA500_0008);
    nx();

    // Response back-pressure, then reset while the response is pending.
    host_rsp_ready = 1'b0;
    host_req(1'b0, 5, 32'h0, 4'h0);
    nx(); host_valid = 1'b0;
    nx(); host_valid = 1'b1;
    nx(); nx();
    arstn = 1'b0; pix_req = 1'b1; pix_addr = 10'd9;
    at_neg();
    chk("lit_rst2_mem_en", 32'(mem_en), 32'd0);
    chk("lit_rst2_rsp_still", 32'(host_rsp_valid), 32'd1);
    nx();
    arstn = 1'b1; pix_req = 1'b0; host_valid = 1'b0;
    at_neg();
    chk("lit_rst2_rsp_valid", 32'(host_rsp_valid), 32'd0);
    chk("lit_rst2_stall", 32'(host_stall_cnt), 32'd0);
    chk("lit_rst2_pix_rvalid", 32'(pix_rvalid), 32'd0);
    nx();

    // Mixed traffic with occasional resets; the compare process checks it.
    for (int i = 0; i < 400; i++) begin
      arstn          = ($urandom_range(0, 99) != 0);
      pix_req        = ($urandom_range(0, 2) == 0);
      pix_addr       = ADDR_W'($urandom_range(0, DEPTH - 1));
      host_req(1'($urandom_range(0, 1)), $urandom_range(0, 620), $urandom, 4'($urandom_range(0, 15)));
      host_valid     = ($urandom_range(0, 1) == 1);
      host_rsp_ready = ($urandom_range(0, 3) != 0);
      nx();
    end

    arstn = 1'b1; pix_req = 1'b0; host_valid = 1'b0; host_rsp_ready = 1'b1;
    nx(); nx(); nx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
